prog_dumper: RTL and testbench
==============================

// Module: prog_dumper
// PURPOSE
//  Reads a block of program memory and sends it out over UART, 8N1, LSB first.
//  Readback counterpart of the UART program loader: the host uploads an image,
//  then triggers a dump and compares the returned stream byte-for-byte.
//  Single clock domain; bit timing comes from a clk divider.
// PARAMETERS
//  CLKS_PER_BIT  12  clk cycles per UART bit (start, data, stop); must be >= 2
//  RD_LATENCY    2   cycles from read strobe to rdata valid; must be >= 1
//  ADR_WIDTH     21  memory address width
// PORTS
//  clk        in   1          clock
//  reset      in   1          reset, synchronous, active-high
//  start      in   1          1-cycle request; sampled only in IDLE
//  start_adr  in   ADR_WIDTH  first byte address; latched on accepted start
//  length     in   ADR_WIDTH  byte count; latched on accepted start; 0 = none
//  adr        out  ADR_WIDTH  memory read address
//  read       out  1          read strobe, 1 cycle per byte
//  rdata      in   8          memory data, valid RD_LATENCY cycles after read
//  tx         out  1          UART line, idle high
//  busy       out  1          high from cycle after accepted start through DONE
//  done       out  1          1-cycle pulse when dump completes
// BEHAVIOUR
//  Reset values: tx=1, read=0, busy=0, done=0, adr=0. All outputs registered.
//  FSM: IDLE -> FETCH -> WAIT -> START -> DATA -> STOP -> (FETCH | DONE) -> IDLE.
//  IDLE: tx=1. start=1 with length!=0: latch adr=start_adr, remaining=length, go FETCH.
//    start=1 with length==0: go DONE, no read, no frame. start while busy: ignored.
//  FETCH (1 cycle): read=1, adr stable. Next state WAIT.
//  WAIT (RD_LATENCY cycles): tx=1. Capture rdata into shift reg on the edge
//    ending the RD_LATENCY-th WAIT cycle, then go START.
//  START: tx=0 for CLKS_PER_BIT cycles. DATA: bits 0..7 LSB first,
//    CLKS_PER_BIT cycles each. STOP: tx=1 for CLKS_PER_BIT cycles.
//  End of STOP: remaining-=1, adr+=1 (mod 2^ADR_WIDTH, wraps silently).
//    remaining==0 -> DONE, else FETCH.
//  DONE (1 cycle): done=1, busy=1, tx=1; then IDLE (busy=0).
//  Timing: start accepted at cycle 0 -> read at cycle 1 -> start bit begins at
//    cycle 2+RD_LATENCY. Inter-frame idle-high gap = 1+RD_LATENCY cycles.
//    Frame length = 10*CLKS_PER_BIT cycles exactly.
//  rdata is sampled only at the capture edge; all other cycles ignored.
//  reset mid-frame: next cycle tx=1, FSM IDLE. The truncated frame is accepted
//    as is; the host must resync. No done pulse.
//  length==2^ADR_WIDTH-1 is legal; the counter must not overflow.
// STRUCTURE
//  Shared include uart_defs.vh: FSM state encodings, frame bit count (8),
//    stop-bit count (1). This include is shared with the loader.
//  Sub-module uart_tx_serializer: byte+valid in, ready out, tx out;
//    owns the bit divider, bit index and shift register.
//  prog_dumper keeps the address/count FSM and the memory read timing.
// TESTING
//  T1 CLKS_PER_BIT=12, RD_LATENCY=2; start_adr=0x00010, length=1, mem[0x10]=0xA5 ->
//     one read at adr 0x10; tx 0,1,0,1,0,0,1,0,1,1 each 12 clk; one done pulse.
//  T2 length=3 from 0x1FFFFF -> reads 0x1FFFFF, 0x000000, 0x000001 (wrap);
//     3 frames; tx high for exactly 3 cycles between frames.
//  T3 length=0 -> no read, tx stays 1, done 1 cycle after start; busy high 1 cycle.
//  T4 start pulsed again mid-dump -> ignored; frame count and addresses unchanged.
//  T5 reset asserted in DATA bit 3 -> tx=1 next cycle, busy=0, no done;
//     a new start dumps correctly from its start_adr.
//  T6 RD_LATENCY=1, 4; rdata driven X outside the valid cycle -> correct bytes,
//     first start bit at cycle 2+RD_LATENCY.

Source files
------------

// File: rtl/prog_dumper_pkg.sv
// Shared definitions for the program dumper: state encodings and UART frame shape.
package prog_dumper_pkg;

    // UART frame shape (8N1), shared with the program loader
    localparam int FRAME_BITS = 8;
    localparam int STOP_BITS  = 1;

    // Address/count sequencer states
    typedef enum logic [2:0] {
        D_IDLE  = 3'd0,
        D_FETCH = 3'd1,
        D_WAIT  = 3'd2,
        D_SEND  = 3'd3,
        D_DONE  = 3'd4
    } dump_state_e;

    // Serializer states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } ser_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: owns the bit divider, bit index and shift register.
// ready_o is high when idle and also during the final cycle of the stop bit,
// so a byte offered then is started back-to-back without an idle cycle.
module uart_tx_serializer
    import prog_dumper_pkg::*;
#(
    parameter int CLKS_PER_BIT = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o
);

    localparam int             DIV_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     BIT_LAST  = 3'(FRAME_BITS - 1);
    localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);

    ser_state_e       state_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       idx_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic             last_tick_s;

    assign last_tick_s = (div_q == DIV_LAST);
    assign tx_o        = tx_q;

    // Ready when idle or on the very last cycle of the final stop bit
    always_comb begin
        ready_o = 1'b0;
        if (state_q == S_IDLE) begin
            ready_o = 1'b1;
        end else if ((state_q == S_STOP) && last_tick_s && (idx_q == STOP_LAST)) begin
            ready_o = 1'b1;
        end else begin
            ready_o = 1'b0;
        end
    end

    // Frame sequencer: start bit, data bits LSB first, stop bit(s)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    div_q <= '0;
                    idx_q <= 3'd0;
                    tx_q  <= 1'b1;
                    if (valid_i) begin
                        shift_q <= byte_i;
                        tx_q    <= 1'b0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (last_tick_s) begin
                        div_q   <= '0;
                        idx_q   <= 3'd0;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        state_q <= S_DATA;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                S_DATA: begin
                    if (last_tick_s) begin
                        div_q <= '0;
                        if (idx_q == BIT_LAST) begin
                            idx_q   <= 3'd0;
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                S_STOP: begin
                    if (last_tick_s) begin
                        div_q <= '0;
                        if (idx_q == STOP_LAST) begin
                            idx_q <= 3'd0;
                            if (valid_i) begin
                                shift_q <= byte_i;
                                tx_q    <= 1'b0;
                                state_q <= S_START;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= S_IDLE;
                            end
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    div_q   <= '0;
                    idx_q   <= 3'd0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/prog_dumper.sv
// Program memory dumper: walks start_adr..start_adr+length-1, reads each byte
// with a fixed read latency and streams it out as an 8N1 UART frame.
module prog_dumper
    import prog_dumper_pkg::*;
#(
    parameter int CLKS_PER_BIT = 12,
    parameter int RD_LATENCY   = 2,
    parameter int ADR_WIDTH    = 21
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [ADR_WIDTH-1:0] start_adr_i,
    input  logic [ADR_WIDTH-1:0] length_i,
    output logic [ADR_WIDTH-1:0] adr_o,
    output logic                 read_o,
    input  logic [7:0]           rdata_i,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int               WAIT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LATENCY - 1);

    dump_state_e           state_q;
    logic [ADR_WIDTH-1:0]  adr_q;
    logic [ADR_WIDTH-1:0]  adr_d;
    logic [ADR_WIDTH-1:0]  rem_q;
    logic [ADR_WIDTH-1:0]  rem_d;
    logic [WAIT_W-1:0]     wait_q;
    logic                  read_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  ser_valid_s;
    logic                  ser_ready_s;
    logic                  last_byte_s;

    assign adr_o  = adr_q;
    assign read_o = read_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

    // Next address wraps silently; remaining count only decrements from >= 1
    always_comb begin
        adr_d       = adr_q + ADR_WIDTH'(1);
        rem_d       = rem_q - ADR_WIDTH'(1);
        last_byte_s = (rem_q == ADR_WIDTH'(1));
        ser_valid_s = (state_q == D_WAIT) && (wait_q == WAIT_LAST);
    end

    // Address/count sequencer with registered memory and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= D_IDLE;
            adr_q   <= '0;
            rem_q   <= '0;
            wait_q  <= '0;
            read_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                D_IDLE: begin
                    read_q <= 1'b0;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    wait_q <= '0;
                    if (start_i) begin
                        busy_q <= 1'b1;
                        if (length_i != '0) begin
                            adr_q   <= start_adr_i;
                            rem_q   <= length_i;
                            read_q  <= 1'b1;
                            state_q <= D_FETCH;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= D_DONE;
                        end
                    end
                end
                D_FETCH: begin
                    read_q  <= 1'b0;
                    wait_q  <= '0;
                    state_q <= D_WAIT;
                end
                D_WAIT: begin
                    // The serializer captures rdata on the edge that leaves this state
                    if (wait_q == WAIT_LAST) begin
                        state_q <= D_SEND;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                D_SEND: begin
                    if (ser_ready_s) begin
                        adr_q <= adr_d;
                        rem_q <= rem_d;
                        if (last_byte_s) begin
                            done_q  <= 1'b1;
                            state_q <= D_DONE;
                        end else begin
                            read_q  <= 1'b1;
                            state_q <= D_FETCH;
                        end
                    end
                end
                D_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= D_IDLE;
                end
                default: begin
                    state_q <= D_IDLE;
                    read_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .clk     (clk),
        .reset   (reset),
        .byte_i  (rdata_i),
        .valid_i (ser_valid_s),
        .ready_o (ser_ready_s),
        .tx_o    (tx_o)
    );

endmodule

// File: tb/tb_prog_dumper.sv
// Scoreboard bench for prog_dumper: three instances cover read latencies 2, 1 and 4.
module tb_prog_dumper;

    localparam int N  = 3;
    localparam int AW = 21;

    function automatic int rl_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic int cpb_of(input int i);
        case (i)
            0:       return 12;
            default: return 4;
        endcase
    endfunction

    // Memory image seen by every instance
    function automatic logic [7:0] mem_f(input logic [AW-1:0] a);
        if (a == 21'h00010) return 8'hA5;
        return a[7:0] ^ {a[19:16], a[11:8]} ^ 8'h3C;
    endfunction

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_s [N];
    logic [AW-1:0] sadr_s  [N];
    logic [AW-1:0] len_s   [N];
    logic [AW-1:0] adr_s   [N];
    logic          read_s  [N];
    logic          tx_s    [N];
    logic          busy_s  [N];
    logic          done_s  [N];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [AW-1:0] exp_adr  [N][$];
    logic [7:0]    exp_byte [N][$];
    int            exp_done [N][$];

    int         ph     [N];
    int         rdc    [N];
    int         last_s [N];
    int         fend   [N];
    int         ferr   [N];
    bit         first  [N];
    logic [7:0] fexp   [N];
    logic [7:0] fact   [N];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int RLG  = rl_of(g);
        localparam int CPBG = cpb_of(g);
        logic [RLG-1:0] pv = '0;
        logic [AW-1:0]  pa [RLG];
        logic [7:0]     rdata_g;

        // Memory model: data valid only RLG cycles after the read strobe
        always @(posedge clk) begin
            for (int k = RLG - 1; k > 0; k--) begin
                pv[k] <= pv[k-1];
                pa[k] <= pa[k-1];
            end
            pv[0] <= read_s[g];
            pa[0] <= adr_s[g];
        end
        assign rdata_g = pv[RLG-1] ? mem_f(pa[RLG-1]) : 8'hxx;

        prog_dumper #(
            .CLKS_PER_BIT (CPBG),
            .RD_LATENCY   (RLG),
            .ADR_WIDTH    (AW)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .start_i     (start_s[g]),
            .start_adr_i (sadr_s[g]),
            .length_i    (len_s[g]),
            .adr_o       (adr_s[g]),
            .read_o      (read_s[g]),
            .rdata_i     (rdata_g),
            .tx_o        (tx_s[g]),
            .busy_o      (busy_s[g]),
            .done_o      (done_s[g])
        );
    end

    // Monitor: reads, UART frames and done pulses checked against the queues
    always @(negedge clk) begin
        int         bitn;
        int         cpb;
        logic [9:0] pat;
        cyc++;
        for (int i = 0; i < N; i++) begin
            cpb = cpb_of(i);
            if (reset) begin
                exp_adr[i].delete();
                exp_byte[i].delete();
                exp_done[i].delete();
                ph[i]    = -1;
                first[i] = 1'b1;
            end else begin
                if (read_s[i]) begin
                    check("read_expected", exp_adr[i].size() > 0, 1);
                    if (exp_adr[i].size() > 0) check("read_adr", adr_s[i], exp_adr[i].pop_front());
                    rdc[i] = cyc;
                end
                if (ph[i] < 0 && tx_s[i] == 1'b0) begin
                    check("frame_expected", exp_byte[i].size() > 0, 1);
                    fexp[i] = (exp_byte[i].size() > 0) ? exp_byte[i].pop_front() : 8'h00;
                    check("start_bit_time", cyc, rdc[i] + 1 + rl_of(i));
                    if (!first[i]) check("frame_spacing", cyc - last_s[i], 10 * cpb + 1 + rl_of(i));
                    first[i]  = 1'b0;
                    last_s[i] = cyc;
                    ph[i]     = 0;
                    ferr[i]   = 0;
                    fact[i]   = 8'h00;
                end
                if (ph[i] >= 0) begin
                    bitn = ph[i] / cpb;
                    pat  = {1'b1, fexp[i], 1'b0};
                    if (tx_s[i] !== pat[bitn]) ferr[i]++;
                    if ((ph[i] % cpb) == (cpb / 2) && bitn >= 1 && bitn <= 8) fact[i][bitn-1] = tx_s[i];
                    if (ph[i] == 10 * cpb - 1) begin
                        check("frame_bits", {23'd0, ferr[i] != 0, fact[i]}, {24'd0, fexp[i]});
                        fend[i] = cyc;
                        ph[i]   = -1;
                    end else begin
                        ph[i]++;
                    end
                end
                if (done_s[i]) begin
                    check("done_expected", exp_done[i].size() > 0, 1);
                    if (exp_done[i].size() > 0 && exp_done[i].pop_front() != 0)
                        check("done_time", cyc, fend[i] + 1);
                    first[i] = 1'b1;
                end
            end
        end
    end

    task automatic run_dump(input int i, input logic [AW-1:0] a, input logic [AW-1:0] n, input bit poke);
        int budget;
        bit seen_idle;
        for (int k = 0; k < int'(n); k++) begin
            exp_adr[i].push_back(a + AW'(k));
            exp_byte[i].push_back(mem_f(a + AW'(k)));
        end
        exp_done[i].push_back(int'(n));
        start_s[i] = 1'b1;
        sadr_s[i]  = a;
        len_s[i]   = n;
        @(negedge clk);
        start_s[i] = 1'b0;
        sadr_s[i]  = 21'h0AAAA;
        len_s[i]   = 21'd7;
        check("busy_c1", busy_s[i], 1);
        check("read_c1", read_s[i], n != '0);
        if (n == '0) begin
            check("done_c1", done_s[i], 1);
            check("tx_idle_c1", tx_s[i], 1);
            @(negedge clk);
            check("busy_c2", busy_s[i], 0);
            check("done_c2", done_s[i], 0);
        end
        budget    = int'(n) * (10 * cpb_of(i) + rl_of(i) + 2) + 8;
        seen_idle = 1'b0;
        for (int c = 0; c < budget && !seen_idle; c++) begin
            if (poke && c == 25) begin
                start_s[i] = 1'b1;
                sadr_s[i]  = 21'h00777;
                len_s[i]   = 21'd5;
            end else begin
                start_s[i] = 1'b0;
            end
            @(negedge clk);
            seen_idle = !busy_s[i];
        end
        start_s[i] = 1'b0;
        check("dump_finished", seen_idle, 1);
        repeat (2) @(negedge clk);
        check("reads_left", exp_adr[i].size(), 0);
        check("frames_left", exp_byte[i].size(), 0);
        check("dones_left", exp_done[i].size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            start_s[i] = 1'b0;
            sadr_s[i]  = '0;
            len_s[i]   = '0;
            ph[i]      = -1;
            rdc[i]     = 0;
            last_s[i]  = 0;
            fend[i]    = 0;
            first[i]   = 1'b1;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check("rst_tx", tx_s[i], 1);
            check("rst_read", read_s[i], 0);
            check("rst_busy", busy_s[i], 0);
            check("rst_done", done_s[i], 0);
            check("rst_adr", adr_s[i], 0);
        end
        reset = 1'b0;
        @(negedge clk);

        // T1 single byte 0xA5 from 0x10
        run_dump(0, 21'h00010, 21'd1, 1'b0);
        // T2 address wrap across the top of memory
        run_dump(0, 21'h1FFFFF, 21'd3, 1'b0);
        // T3 zero length
        run_dump(0, 21'h00055, 21'd0, 1'b0);
        // T4 start pulsed mid-dump is ignored
        run_dump(0, 21'h00300, 21'd2, 1'b1);

        // T5 reset during data bit 3
        exp_adr[0].push_back(21'h00100);
        exp_byte[0].push_back(mem_f(21'h00100));
        start_s[0] = 1'b1;
        sadr_s[0]  = 21'h00100;
        len_s[0]   = 21'd2;
        @(negedge clk);
        start_s[0] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx_s[0] == 1'b0) break;
        end
        check("t5_frame_started", tx_s[0], 0);
        repeat (4 * 12 + 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_tx_after_reset", tx_s[0], 1);
        check("t5_busy_after_reset", busy_s[0], 0);
        check("t5_done_after_reset", done_s[0], 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_busy_idle", busy_s[0], 0);
        run_dump(0, 21'h00200, 21'd2, 1'b0);

        // T6 other read latencies
        run_dump(1, 21'h00040, 21'd2, 1'b0);
        run_dump(2, 21'h1FFFFE, 21'd3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
